// File: rtl/cbus_arbiter.sv
// cbus_arbiter: two-master bus arbiter with watchdog; define CBUS_ARB_RR_EN for round-robin tie-break (default: master 1 wins ties)
module cbus_arbiter #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_m0_valid,
  input  logic        i_m1_valid,
  input  logic [63:0] i_m0_addr,
  input  logic [63:0] i_m1_addr,
  input  logic [2:0]  i_m0_size,
  input  logic [2:0]  i_m1_size,
  input  logic [7:0]  i_m0_strobe,
  input  logic [7:0]  i_m1_strobe,
  input  logic [63:0] i_m0_wdata,
  input  logic [63:0] i_m1_wdata,
  output logic        o_m0_addr_ok,
  output logic        o_m1_addr_ok,
  output logic        o_m0_data_ok,
  output logic        o_m1_data_ok,
  output logic [63:0] o_m0_rdata,
  output logic [63:0] o_m1_rdata,
  output logic        o_s_valid,
  output logic [63:0] o_s_addr,
  output logic [2:0]  o_s_size,
  output logic [7:0]  o_s_strobe,
  output logic [63:0] o_s_wdata,
  input  logic        i_s_addr_ok,
  input  logic        i_s_data_ok,
  input  logic [63:0] i_s_rdata,
  output logic        o_err_timeout
);
  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;
  state_t      r_state, w_next, w_tie;
  logic        r_last;
  logic [15:0] r_cnt;
  logic        r_err;
  logic        w_g0, w_g1;
`ifdef CBUS_ARB_RR_EN
  assign w_tie = r_last ? GNT0 : GNT1;
`else
  assign w_tie = GNT1;
`endif
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE) r_cnt <= '0;
      else if (!i_s_data_ok && r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
      if (r_state != IDLE && i_s_data_ok) r_last <= (r_state == GNT1);
      if (TIMEOUT != 0 && {16'd0, r_cnt} == TIMEOUT) r_err <= 1'b1;
    end
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = (i_m0_valid && i_m1_valid) ? w_tie :
                        i_m0_valid ? GNT0 : i_m1_valid ? GNT1 : IDLE;
      default: w_next = i_s_data_ok ? IDLE : r_state;
    endcase
  end
  always_comb begin
    w_g0          = (r_state == GNT0);
    w_g1          = (r_state == GNT1);
    o_s_valid     = w_g0 ? i_m0_valid  : w_g1 ? i_m1_valid  : 1'b0;
    o_s_addr      = w_g0 ? i_m0_addr   : w_g1 ? i_m1_addr   : 64'd0;
    o_s_size      = w_g0 ? i_m0_size   : w_g1 ? i_m1_size   : 3'd0;
    o_s_strobe    = w_g0 ? i_m0_strobe : w_g1 ? i_m1_strobe : 8'd0;
    o_s_wdata     = w_g0 ? i_m0_wdata  : w_g1 ? i_m1_wdata  : 64'd0;
    o_m0_addr_ok  = w_g0 & i_s_addr_ok;
    o_m1_addr_ok  = w_g1 & i_s_addr_ok;
    o_m0_data_ok  = w_g0 & i_s_data_ok;
    o_m1_data_ok  = w_g1 & i_s_data_ok;
    o_m0_rdata    = w_g0 ? i_s_rdata : 64'd0;
    o_m1_rdata    = w_g1 ? i_s_rdata : 64'd0;
    o_err_timeout = r_err;
  end
endmodule

// File: tb/tb_cbus_arbiter.sv
// tb_cbus_arbiter: directed checks of grant, pass-through, tie-break, watchdog and async reset
module tb_cbus_arbiter;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        m0_valid = 0, m1_valid = 0;
  logic [63:0] m0_addr = 0, m1_addr = 0, m0_wdata = 0, m1_wdata = 0;
  logic [2:0]  m0_size = 0, m1_size = 0;
  logic [7:0]  m0_strobe = 0, m1_strobe = 0;
  logic        m0_addr_ok, m1_addr_ok, m0_data_ok, m1_data_ok;
  logic [63:0] m0_rdata, m1_rdata;
  logic        s_valid;
  logic [63:0] s_addr, s_wdata;
  logic [2:0]  s_size;
  logic [7:0]  s_strobe;
  logic        s_addr_ok = 0, s_data_ok = 0;
  logic [63:0] s_rdata = 0;
  logic        err_timeout;
  int          n_tests = 0, n_fail = 0;
  logic [63:0] tie2_addr;

  cbus_arbiter #(.TIMEOUT(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_m0_valid(m0_valid), .i_m1_valid(m1_valid),
    .i_m0_addr(m0_addr), .i_m1_addr(m1_addr),
    .i_m0_size(m0_size), .i_m1_size(m1_size),
    .i_m0_strobe(m0_strobe), .i_m1_strobe(m1_strobe),
    .i_m0_wdata(m0_wdata), .i_m1_wdata(m1_wdata),
    .o_m0_addr_ok(m0_addr_ok), .o_m1_addr_ok(m1_addr_ok),
    .o_m0_data_ok(m0_data_ok), .o_m1_data_ok(m1_data_ok),
    .o_m0_rdata(m0_rdata), .o_m1_rdata(m1_rdata),
    .o_s_valid(s_valid), .o_s_addr(s_addr), .o_s_size(s_size),
    .o_s_strobe(s_strobe), .o_s_wdata(s_wdata),
    .i_s_addr_ok(s_addr_ok), .i_s_data_ok(s_data_ok), .i_s_rdata(s_rdata),
    .o_err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    m0_addr = 64'h8000_0000; m0_size = 3'd2;
    m1_addr = 64'h1003;      m1_size = 3'd0; m1_strobe = 8'h08; m1_wdata = 64'hAB00_0000;
    #12;
    chk("rst_s_valid", s_valid, 0);
    chk("rst_err", err_timeout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    // single read from master 0
    m0_valid = 1;
    #1 chk("idle_no_valid", s_valid, 0);
    tick();
    chk("rd_s_valid", s_valid, 1);
    chk("rd_s_addr", s_addr, 64'h8000_0000);
    chk("rd_s_size", s_size, 2);
    chk("rd_s_strobe", s_strobe, 0);
    s_addr_ok = 1;
    #1 chk("rd_m0_addr_ok", m0_addr_ok, 1);
    chk("rd_m1_addr_ok", m1_addr_ok, 0);
    s_addr_ok = 0; s_data_ok = 1; s_rdata = 64'h1234;
    #1 chk("rd_m0_rdata", m0_rdata, 64'h1234);
    chk("rd_m0_data_ok", m0_data_ok, 1);
    chk("rd_m1_data_ok", m1_data_ok, 0);
    chk("rd_m1_rdata", m1_rdata, 0);
    tick();
    s_data_ok = 0; m0_valid = 0;
    #1 chk("rd_back_idle", s_valid, 0);
    // contention after m0 grant: both policies pick m1
    m0_valid = 1; m1_valid = 1;
    tick();
    chk("tie1_addr", s_addr, 64'h1003);
    s_data_ok = 1;
    tick();
    s_data_ok = 0;
    #1 chk("tie1_bubble", s_valid, 0);
    m1_valid = 0;
    tick();
    chk("tie1_then_m0", s_addr, 64'h8000_0000);
    s_addr_ok = 1;
    #1 chk("tie1_m1_no_addr_ok", m1_addr_ok, 0);
    s_addr_ok = 0; s_data_ok = 1;
    tick();
    s_data_ok = 0; m0_valid = 0;
    // write pass-through from m1
    m1_valid = 1;
    tick();
    chk("wr_strobe", s_strobe, 8'h08);
    chk("wr_wdata", s_wdata, 64'hAB00_0000);
    chk("wr_addr", s_addr, 64'h1003);
    s_data_ok = 1;
    #1 chk("wr_m1_data_ok", m1_data_ok, 1);
    tick();
    s_data_ok = 0;
    #1 chk("wr_back_idle", s_valid, 0);
    m1_valid = 0;
    // tie after m1 grant: policy decides
`ifdef CBUS_ARB_RR_EN
    tie2_addr = 64'h8000_0000;
`else
    tie2_addr = 64'h1003;
`endif
    m0_valid = 1; m1_valid = 1;
    tick();
    chk("tie2_addr", s_addr, tie2_addr);
    s_data_ok = 1;
    tick();
    s_data_ok = 0; m0_valid = 0; m1_valid = 0;
    tick();
    // watchdog, TIMEOUT=4
    m0_valid = 1;
    tick();
    tick(); tick(); tick();
    chk("wd_not_yet", err_timeout, 0);
    tick(); tick(); tick();
    chk("wd_err_set", err_timeout, 1);
    chk("wd_grant_held", s_addr, 64'h8000_0000);
    m0_valid = 0; m1_valid = 1;
    #1 chk("wd_valid_follows", s_valid, 0);
    tick();
    chk("wd_no_regrant", s_addr, 64'h8000_0000);
    m0_valid = 1; s_data_ok = 1;
    tick();
    s_data_ok = 0; m0_valid = 0; m1_valid = 0;
    tick();
    chk("wd_sticky", err_timeout, 1);
    // async reset in the middle of a GNT1 transaction
    m1_valid = 1; s_addr_ok = 1;
    tick();
    chk("rst_pre_valid", s_valid, 1);
    #1 rst_n = 0;
    #1 chk("rst_mid_valid", s_valid, 0);
    chk("rst_mid_addr_ok", m1_addr_ok, 0);
    chk("rst_mid_err", err_timeout, 0);
    m1_valid = 0; s_addr_ok = 0;
    @(negedge clk);
    rst_n = 1;
    tick();
    chk("rst_after_idle", s_valid, 0);
    m1_valid = 1;
    tick();
    chk("rst_regrant", s_valid, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
